// File: rtl/svm_pkg.sv
// Shared widths, FSM state encoding and saturation helpers for the SVM
// sequential classifier.
package svm_pkg;

  localparam int unsigned FEAT_W = 16;
  localparam int unsigned ACC_W  = 48;
  localparam int unsigned SUM_W  = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_FINISH
  } state_t;

  localparam logic [SUM_W-1:0]        SUM_MAX = 32'h7FFF_FFFF;
  localparam logic [SUM_W-1:0]        SUM_MIN = 32'h8000_0000;
  localparam logic signed [ACC_W:0]   SAT_HI  = 49'sd2147483647;
  localparam logic signed [ACC_W:0]   SAT_LO  = -49'sd2147483648;

  // Clamp a biased accumulator value into the signed 32-bit output range.
  function automatic logic [SUM_W-1:0] sat_sum(input logic signed [ACC_W:0] v);
    logic [SUM_W-1:0] r;
    if (v > SAT_HI) begin
      r = SUM_MAX;
    end else if (v < SAT_LO) begin
      r = SUM_MIN;
    end else begin
      r = v[SUM_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/svm_mac.sv
// Feature register plus multiply-accumulate: the product of the registered
// feature and the ROM weight is accumulated one cycle after acceptance.
module svm_mac
  import svm_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     load,
  input  logic [FEAT_W-1:0]        feat_in,
  input  logic [FEAT_W-1:0]        w_data,
  output logic signed [ACC_W-1:0]  acc
);

  logic signed [FEAT_W-1:0]  feat_reg;
  logic                      pend;
  logic signed [SUM_W-1:0]   prod;

  assign prod = feat_reg * $signed(w_data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      feat_reg <= '0;
      pend     <= 1'b0;
      acc      <= '0;
    end else if (clear) begin
      feat_reg <= '0;
      pend     <= 1'b0;
      acc      <= '0;
    end else begin
      pend <= load;
      if (load) begin
        feat_reg <= $signed(feat_in);
      end
      // w_data matching feat_reg arrives the cycle after acceptance
      if (pend) begin
        acc <= acc + {{(ACC_W-SUM_W){prod[SUM_W-1]}}, prod};
      end
    end
  end

endmodule

// File: rtl/svm_seq_controller.sv
// Sequential linear-SVM classifier: streams N features against a weight ROM,
// adds a bias, saturates and reports the decision value.
module svm_seq_controller
  import svm_pkg::*;
#(
  parameter int                 N    = 8100,
  parameter int                 AW   = $clog2(N),
  parameter logic signed [31:0] BIAS = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              feat_valid,
  input  logic [15:0]       feat_data,
  output logic              feat_ready,
  output logic [AW-1:0]     w_addr,
  input  logic [15:0]       w_data,
  output logic              busy,
  output logic              done,
  output logic [31:0]       sum,
  output logic              is_missile
);

  localparam logic [AW-1:0] LAST = AW'(N - 1);

  state_t                   state, state_nx;
  logic [AW-1:0]            k;
  logic                     accept;
  logic                     clear;
  logic                     load_res;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W:0]    biased;
  logic [SUM_W-1:0]         result;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Abort outranks acceptance, so accept is only raised on the non-abort path.
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    clear    = 1'b0;
    load_res = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !abort) begin
          state_nx = ST_LOAD;
          clear    = 1'b1;
        end
      end
      ST_LOAD: begin
        if (abort) begin
          state_nx = ST_IDLE;
        end else if (feat_valid) begin
          accept = 1'b1;
          if (k == LAST) begin
            state_nx = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        state_nx = abort ? ST_IDLE : ST_FINISH;
      end
      ST_FINISH: begin
        state_nx = ST_IDLE;
        load_res = !abort;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  assign feat_ready = (state == ST_LOAD);
  assign busy       = (state != ST_IDLE);
  assign w_addr     = (state == ST_LOAD) ? k : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k <= '0;
    end else if (clear) begin
      k <= '0;
    end else if (accept) begin
      k <= k + 1'b1;
    end
  end

  svm_mac u_mac (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear),
    .load    (accept),
    .feat_in (feat_data),
    .w_data  (w_data),
    .acc     (acc)
  );

  assign biased = {acc[ACC_W-1], acc} + {{(ACC_W+1-32){BIAS[31]}}, BIAS};
  assign result = sat_sum(biased);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum        <= '0;
      is_missile <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= load_res;
      if (load_res) begin
        sum        <= result;
        is_missile <= !result[SUM_W-1] && (result != '0);
      end
    end
  end

endmodule

// File: tb/tb_svm_seq_controller.sv
// Directed bench: three controller instances (N=4 bias 0, N=4 bias 15,
// N=8100 bias 0) driven from a shared feature stream with per-instance start.
module tb_svm_seq_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  start_v;
  logic        abort;
  logic        feat_valid;
  logic [15:0] feat_data;

  logic [2:0]  ready_v, busy_v, done_v, miss_v;
  logic signed [31:0] sum0, sum1, sum2;
  logic [1:0]  addr0, addr1;
  logic [12:0] addr2;
  logic [15:0] w0, w1, w2;

  logic signed [15:0] wtab0 [4];
  logic signed [15:0] wtab1 [4];
  logic signed [15:0] wval2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    w0 <= wtab0[addr0];
    w1 <= wtab1[addr1];
    w2 <= (addr2 < 13'd8100) ? wval2 : 16'sd0;
  end

  svm_seq_controller #(.N(4), .BIAS(32'sd0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .abort(abort),
    .feat_valid(feat_valid), .feat_data(feat_data), .feat_ready(ready_v[0]),
    .w_addr(addr0), .w_data(w0), .busy(busy_v[0]), .done(done_v[0]),
    .sum(sum0), .is_missile(miss_v[0]));

  svm_seq_controller #(.N(4), .BIAS(32'sd15)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .abort(abort),
    .feat_valid(feat_valid), .feat_data(feat_data), .feat_ready(ready_v[1]),
    .w_addr(addr1), .w_data(w1), .busy(busy_v[1]), .done(done_v[1]),
    .sum(sum1), .is_missile(miss_v[1]));

  svm_seq_controller #(.N(8100), .BIAS(32'sd0)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .abort(abort),
    .feat_valid(feat_valid), .feat_data(feat_data), .feat_ready(ready_v[2]),
    .w_addr(addr2), .w_data(w2), .busy(busy_v[2]), .done(done_v[2]),
    .sum(sum2), .is_missile(miss_v[2]));

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic signed [31:0] sum_of(input int sel);
    case (sel)
      0:       return sum0;
      1:       return sum1;
      default: return sum2;
    endcase
  endfunction

  task automatic start_pulse(input int sel);
    @(negedge clk);
    start_v[sel] = 1'b1;
    @(negedge clk);
    start_v[sel] = 1'b0;
  endtask

  // Present one feature (optionally after a one-cycle valid gap) and return
  // just after the clock edge that accepts it.
  task automatic send(input int sel, input logic signed [15:0] d, input int gap);
    int n;
    @(negedge clk);
    if (gap != 0) begin
      feat_valid = 1'b0;
      @(negedge clk);
    end
    feat_valid = 1'b1;
    feat_data  = d;
    n = 0;
    while (!ready_v[sel] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ready_v[sel]) begin
      check("send_ready_timeout", 0, 1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic finish_check(input int sel, input string tag,
                              input logic signed [63:0] exp_sum,
                              input logic exp_miss);
    feat_valid = 1'b0;
    @(posedge clk); #1;
    check({tag, "_done_early"}, done_v[sel], 0);
    @(posedge clk); #1;
    check({tag, "_done"}, done_v[sel], 1);
    check({tag, "_sum"}, sum_of(sel), exp_sum);
    check({tag, "_missile"}, miss_v[sel], exp_miss);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, done_v[sel], 0);
    check({tag, "_sum_hold"}, sum_of(sel), exp_sum);
  endtask

  task automatic run4(input int sel, input string tag,
                      input logic signed [15:0] f [4], input int gap,
                      input logic signed [63:0] exp_sum, input logic exp_miss);
    start_pulse(sel);
    for (int i = 0; i < 4; i++) begin
      send(sel, f[i], gap);
    end
    finish_check(sel, tag, exp_sum, exp_miss);
  endtask

  task automatic no_done_window(input string tag, input int cycles);
    int pulses;
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (done_v[0]) pulses++;
    end
    check(tag, pulses, 0);
  endtask

  initial begin
    rst_n      = 1'b0;
    start_v    = '0;
    abort      = 1'b0;
    feat_valid = 1'b0;
    feat_data  = '0;
    wtab0      = '{16'sd1, 16'sd1, 16'sd1, 16'sd1};
    wtab1      = '{-16'sd3, 16'sd0, 16'sd0, 16'sd0};
    wval2      = 16'sd32767;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sum", sum0, 0);
    check("rst_missile", miss_v[0], 0);
    check("rst_done", done_v[0], 0);
    check("rst_busy", busy_v, 0);
    check("rst_ready", ready_v, 0);
    check("rst_addr", addr0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run4(0, "basic", '{16'sd2, 16'sd2, 16'sd2, 16'sd2}, 0, 8, 1'b1);
    run4(0, "neg", '{-16'sd1, -16'sd2, -16'sd3, -16'sd4}, 0, -10, 1'b0);

    // Abort after two accepts, with a valid feature offered in the abort cycle.
    start_pulse(0);
    send(0, 16'sd2, 0);
    send(0, 16'sd2, 0);
    @(negedge clk);
    feat_valid = 1'b1;
    feat_data  = 16'sd2;
    abort      = 1'b1;
    @(posedge clk); #1;
    abort      = 1'b0;
    feat_valid = 1'b0;
    check("abort_busy", busy_v[0], 0);
    no_done_window("abort_no_done", 6);
    check("abort_sum_hold", sum0, -10);
    check("abort_missile_hold", miss_v[0], 0);
    run4(0, "after_abort", '{16'sd2, 16'sd2, 16'sd2, 16'sd2}, 0, 8, 1'b1);

    // start while busy must not restart the accumulation
    start_pulse(0);
    send(0, 16'sd3, 0);
    start_v[0] = 1'b1;
    send(0, 16'sd1, 0);
    start_v[0] = 1'b0;
    send(0, 16'sd1, 0);
    send(0, 16'sd1, 0);
    finish_check(0, "start_busy", 6, 1'b1);

    @(negedge clk);
    start_v[0] = 1'b1;
    abort      = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    abort      = 1'b0;
    check("start_abort_idle", busy_v[0], 0);

    run4(0, "gapped", '{16'sd2, 16'sd2, 16'sd2, 16'sd2}, 1, 8, 1'b1);
    run4(1, "bias", '{16'sd5, 16'sd7, 16'sd7, 16'sd7}, 0, 0, 1'b0);

    // Reset after third accept clears outputs asynchronously.
    start_pulse(0);
    send(0, 16'sd2, 0);
    send(0, 16'sd2, 0);
    send(0, 16'sd2, 0);
    rst_n = 1'b0;
    #1;
    check("midrst_sum", sum0, 0);
    check("midrst_missile", miss_v[0], 0);
    check("midrst_busy", busy_v[0], 0);
    check("midrst_ready", ready_v[0], 0);
    check("midrst_addr", addr0, 0);
    check("midrst_done", done_v[0], 0);
    feat_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    no_done_window("midrst_no_done", 6);
    check("midrst_idle", busy_v[0], 0);

    start_pulse(2);
    for (int i = 0; i < 8100; i++) begin
      send(2, 16'sd32767, 0);
    end
    finish_check(2, "sat_pos", 64'sd2147483647, 1'b1);

    start_pulse(2);
    for (int i = 0; i < 8100; i++) begin
      send(2, -16'sd32768, 0);
    end
    finish_check(2, "sat_neg", -64'sd2147483648, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
